scene_object_streamer: RTL and testbench
========================================

# scene_object_streamer

Parametrised successor to the combinational scene model table. It holds four built-in models: cube, pyramid, octahedron and tetrahedron. On a frame request it streams that model's triangles one at a time over a valid/ready handshake. Each output beat carries fully resolved vertex coordinates and a colour, so the downstream transform/raster stage needs no index lookup. It sits between frame control and the vertex transform stage and sustains one triangle per clock when the consumer is always ready.

## Interface
Parameters:
- COORD_W, 10: signed coordinate width per axis.
- OBJ_SIZE, 80: half-extent of every model, signed. It must satisfy 0 < OBJ_SIZE ≤ 2^(COORD_W-1)-1.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- model_select  in  2  model code: 0 cube, 1 pyramid, 2 octahedron, 3 tetrahedron. Sampled only at frame start.
- frame_start  in  1  one-cycle frame request; honoured only in IDLE.
- out_valid  out  1  a triangle beat is presented.
- out_ready  in  1  the consumer accepts the beat.
- out_v0, out_v1, out_v2  out  3*COORD_W each  vertex packed as {x,y,z}, each field signed.
- out_color  out  12  {r,g,b}, 4 bits per channel.
- out_tri_idx  out  4  triangle index within the model, starting at 0.
- out_last  out  1  this beat is the final triangle of the model.
- num_triangles  out  4  triangle count of the latched model.
- busy  out  1  high while a frame is streaming.
- frame_done  out  1  one-cycle pulse after the last handshake.
- scale_shift  in  2  present only with SCENE_OBJ_SCALE_EN.

## Operation
- Two-state FSM:
  - IDLE: busy=0, out_valid=0.
  - EMIT: busy=1.
- IDLE→EMIT on frame_start. At that edge the block:
  - latches model_select into a model register;
  - loads num_triangles;
  - sets idx=0;
  - registers triangle 0's resolved beat.
- In EMIT, out_valid=1 continuously. A beat is taken when out_valid && out_ready.
  - Handshake with idx < num_triangles-1: idx increments and the next triangle's beat is registered on the same edge, so there is no bubble.
  - Handshake with idx == num_triangles-1: go to IDLE, out_valid drops, frame_done=1 for the next cycle.
- Stall: with out_ready=0, every output holds stable.
- frame_start while in EMIT is ignored; no queueing. model_select changes mid-frame have no effect.
- Models, with S=OBJ_SIZE:
  - Cube: 8 vertices at (±S,±S,±S), 12 triangles.
    - Vertex order: v0(S,S,S) v1(-S,S,S) v2(-S,-S,S) v3(S,-S,S) v4(S,S,-S) v5(-S,S,-S) v6(-S,-S,-S) v7(S,-S,-S).
    - Triangles 0-1 are red, built as 0/1/2 and 0/2/3. Then green, blue, yellow, cyan, magenta, two triangles per face.
  - Pyramid: apex (0,-S,0) plus base at y=+S; 6 triangles (4 sides, 2 base).
  - Octahedron: ±S on each axis; 8 triangles.
  - Tetrahedron: vertices t0(S,S,S) t1(-S,-S,S) t2(-S,S,-S) t3(S,-S,-S).
    - Triangles: 0/1/2 red, 0/3/1 green, 0/2/3 blue, 1/3/2 yellow.
- out_last is a combinational compare of idx against num_triangles-1, registered alongside the beat.
- Arithmetic:
  - Negation is computed at COORD_W width; no overflow is possible given the OBJ_SIZE bound.
  - out_tri_idx is 4 bits; the maximum count is 12.

## Timing
- Reset values:
  - out_valid=0, busy=0, frame_done=0.
  - out_v0/out_v1/out_v2=0, out_color=0, out_tri_idx=0, out_last=0, num_triangles=0.
  - FSM in IDLE.
- Latency: frame_start at edge N gives out_valid=1 in the cycle after N.
- Throughput: 1 beat/cycle with out_ready held high. A full cube frame lasts 12 cycles, with frame_done in the 13th.
- frame_start in the same cycle as frame_done: honoured, because the FSM is already IDLE.
- rst mid-frame: the next cycle shows reset values, the beat is discarded, and frame_done does not pulse.

## Configuration
- SCENE_OBJ_SCALE_EN defined:
  - the scale_shift port exists and is latched with model_select at frame start;
  - every coordinate is arithmetically right-shifted (>>>) by the latched value before registering;
  - examples: -80>>>3 = -10, 80>>>1 = 40.
- Undefined: the port is absent and coordinates are unscaled.

## Test plan
- Reset, then model 0, frame_start, out_ready=1 → 12 consecutive beats with idx 0..11.
  - Beat 0: v0=(80,80,80), v1=(-80,80,80), v2=(-80,-80,80), color F00.
  - out_last only on idx 11; frame_done pulses once; busy high for exactly 12 cycles.
- Model 3, out_ready toggling 1,0,1,0 → 4 beats accepted.
  - Outputs stable during stalls.
  - Beat 1 is t0/t3/t1, color 0F0: v1=(80,-80,-80).
- Model 1 selected, then model_select changed to 2 and frame_start re-pulsed mid-frame → still exactly 6 pyramid beats.
  - Beat 0: v0=(0,-80,0).
  - num_triangles=6.
- Model 2 streaming, rst asserted at idx 4 → next cycle out_valid=0 and busy=0, no frame_done; a following frame_start restarts at idx 0.
- With SCENE_OBJ_SCALE_EN, model 0, scale_shift=3 → beat 0 v2=(-10,-10,10). Check scale_shift changed mid-frame is ignored.
- frame_start asserted in the same cycle as frame_done → a new frame starts, out_valid high the following cycle with idx 0.

Source files
------------

// File: rtl/scene_object_streamer.sv
// scene_object_streamer
//   Streams the triangles of one of four built-in models (cube, pyramid,
//   octahedron, tetrahedron) over a valid/ready handshake, one triangle per
//   beat. Vertex coordinates and colour are fully resolved before they are
//   registered, so the consumer needs no index lookup.
//
//   Optional feature macro: SCENE_OBJ_SCALE_EN. When defined, a scale_shift
//   port is added and every coordinate is arithmetically right-shifted by the
//   value latched at frame start.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   model_select   0 cube, 1 pyramid, 2 octahedron, 3 tetrahedron
//   frame_start    one-cycle frame request, honoured only while idle
//   scale_shift    coordinate right-shift (SCENE_OBJ_SCALE_EN only)
//   out_ready      consumer accepts the presented beat
//   out_valid      a triangle beat is presented
//   out_v0/v1/v2   vertices packed {x,y,z}, each COORD_W signed
//   out_color      {r,g,b}, 4 bits per channel
//   out_tri_idx    triangle index within the model
//   out_last       beat is the final triangle of the model
//   num_triangles  triangle count of the latched model
//   busy           frame streaming
//   frame_done     one-cycle pulse after the last handshake
//
// state | meaning
// IDLE  | waiting for frame_start, out_valid low
// EMIT  | presenting beats, advancing on each handshake

module scene_object_streamer #(
   parameter int COORD_W  = 10,
   parameter int OBJ_SIZE = 80
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             model_select,
   input  logic                   frame_start,
`ifdef SCENE_OBJ_SCALE_EN
   input  logic [1:0]             scale_shift,
`endif
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [3*COORD_W-1:0]   out_v0,
   output logic [3*COORD_W-1:0]   out_v1,
   output logic [3*COORD_W-1:0]   out_v2,
   output logic [11:0]            out_color,
   output logic [3:0]             out_tri_idx,
   output logic                   out_last,
   output logic [3:0]             num_triangles,
   output logic                   busy,
   output logic                   frame_done
);

   typedef enum logic {IDLE, EMIT} state_t;

   // Per-axis coordinate codes: zero, +S, -S
   localparam logic [1:0] CZ = 2'd0;
   localparam logic [1:0] CP = 2'd1;
   localparam logic [1:0] CN = 2'd2;

   localparam logic signed [COORD_W-1:0] S_POS = COORD_W'(OBJ_SIZE);
   localparam logic signed [COORD_W-1:0] S_NEG = -S_POS;

   function automatic logic [3:0] tri_count(input logic [1:0] m);
      case (m)
         2'd0:    return 4'd12;
         2'd1:    return 4'd6;
         2'd2:    return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [5:0] vtx_code(input logic [1:0] m, input logic [2:0] v);
      logic [5:0] c;
      c = {CZ, CZ, CZ};
      case (m)
         2'd0: case (v)
            3'd0: c = {CP, CP, CP};  3'd1: c = {CN, CP, CP};
            3'd2: c = {CN, CN, CP};  3'd3: c = {CP, CN, CP};
            3'd4: c = {CP, CP, CN};  3'd5: c = {CN, CP, CN};
            3'd6: c = {CN, CN, CN};  default: c = {CP, CN, CN};
         endcase
         2'd1: case (v)
            3'd0: c = {CZ, CN, CZ};  3'd1: c = {CP, CP, CP};
            3'd2: c = {CN, CP, CP};  3'd3: c = {CN, CP, CN};
            3'd4: c = {CP, CP, CN};  default: ;
         endcase
         2'd2: case (v)
            3'd0: c = {CP, CZ, CZ};  3'd1: c = {CN, CZ, CZ};
            3'd2: c = {CZ, CP, CZ};  3'd3: c = {CZ, CN, CZ};
            3'd4: c = {CZ, CZ, CP};  3'd5: c = {CZ, CZ, CN};
            default: ;
         endcase
         default: case (v)
            3'd0: c = {CP, CP, CP};  3'd1: c = {CN, CN, CP};
            3'd2: c = {CN, CP, CN};  3'd3: c = {CP, CN, CN};
            default: ;
         endcase
      endcase
      return c;
   endfunction

   // {vertex a, vertex b, vertex c, colour}
   function automatic logic [20:0] tri_lut(input logic [1:0] m, input logic [3:0] i);
      logic [20:0] t;
      t = '0;
      case (m)
         2'd0: case (i)
            4'd0:  t = {3'd0, 3'd1, 3'd2, 12'hF00};
            4'd1:  t = {3'd0, 3'd2, 3'd3, 12'hF00};
            4'd2:  t = {3'd4, 3'd6, 3'd5, 12'h0F0};
            4'd3:  t = {3'd4, 3'd7, 3'd6, 12'h0F0};
            4'd4:  t = {3'd0, 3'd4, 3'd5, 12'h00F};
            4'd5:  t = {3'd0, 3'd5, 3'd1, 12'h00F};
            4'd6:  t = {3'd3, 3'd2, 3'd6, 12'hFF0};
            4'd7:  t = {3'd3, 3'd6, 3'd7, 12'hFF0};
            4'd8:  t = {3'd0, 3'd3, 3'd7, 12'h0FF};
            4'd9:  t = {3'd0, 3'd7, 3'd4, 12'h0FF};
            4'd10: t = {3'd1, 3'd5, 3'd6, 12'hF0F};
            4'd11: t = {3'd1, 3'd6, 3'd2, 12'hF0F};
            default: ;
         endcase
         2'd1: case (i)
            4'd0:  t = {3'd0, 3'd1, 3'd2, 12'hF00};
            4'd1:  t = {3'd0, 3'd2, 3'd3, 12'h0F0};
            4'd2:  t = {3'd0, 3'd3, 3'd4, 12'h00F};
            4'd3:  t = {3'd0, 3'd4, 3'd1, 12'hFF0};
            4'd4:  t = {3'd1, 3'd3, 3'd2, 12'h0FF};
            4'd5:  t = {3'd1, 3'd4, 3'd3, 12'h0FF};
            default: ;
         endcase
         2'd2: case (i)
            4'd0:  t = {3'd2, 3'd4, 3'd0, 12'hF00};
            4'd1:  t = {3'd2, 3'd1, 3'd4, 12'h0F0};
            4'd2:  t = {3'd2, 3'd5, 3'd1, 12'h00F};
            4'd3:  t = {3'd2, 3'd0, 3'd5, 12'hFF0};
            4'd4:  t = {3'd3, 3'd0, 3'd4, 12'h0FF};
            4'd5:  t = {3'd3, 3'd4, 3'd1, 12'hF0F};
            4'd6:  t = {3'd3, 3'd1, 3'd5, 12'hFFF};
            4'd7:  t = {3'd3, 3'd5, 3'd0, 12'h888};
            default: ;
         endcase
         default: case (i)
            4'd0:  t = {3'd0, 3'd1, 3'd2, 12'hF00};
            4'd1:  t = {3'd0, 3'd3, 3'd1, 12'h0F0};
            4'd2:  t = {3'd0, 3'd2, 3'd3, 12'h00F};
            4'd3:  t = {3'd1, 3'd3, 3'd2, 12'hFF0};
            default: ;
         endcase
      endcase
      return t;
   endfunction

   function automatic logic signed [COORD_W-1:0] resolve(input logic [1:0] code,
                                                          input logic [1:0] sh);
      logic signed [COORD_W-1:0] c;
      case (code)
         CP:      c = S_POS;
         CN:      c = S_NEG;
         default: c = '0;
      endcase
      return c >>> sh;
   endfunction

   function automatic logic [3*COORD_W-1:0] vertex(input logic [1:0] m, input logic [2:0] v,
                                                   input logic [1:0] sh);
      logic [5:0] code;
      code = vtx_code(m, v);
      return {resolve(code[5:4], sh), resolve(code[3:2], sh), resolve(code[1:0], sh)};
   endfunction

   state_t                 state_q;
   logic [1:0]             model_q;
   logic [3:0]             idx_q;
   logic [3:0]             num_q;
   logic                   valid_q, busy_q, done_q, last_q;
   logic [3*COORD_W-1:0]   v0_q, v1_q, v2_q;
   logic [11:0]            color_q;

   // Lookup address: triangle 0 of the requested model while idle,
   // otherwise the triangle after the one currently presented.
   logic [1:0]             lut_model;
   logic [3:0]             lut_idx;
   logic [3:0]             lut_num;
   logic [20:0]            lut_tri;
   logic [1:0]             shift_d;

`ifdef SCENE_OBJ_SCALE_EN
   logic [1:0]             scale_q;
   assign shift_d = (state_q == IDLE) ? scale_shift : scale_q;
`else
   assign shift_d = 2'd0;
`endif

   always_comb begin
      lut_model = model_q;
      lut_idx   = idx_q + 4'd1;
      if (state_q == IDLE) begin
         lut_model = model_select;
         lut_idx   = 4'd0;
      end
      lut_num = tri_count(lut_model);
      lut_tri = tri_lut(lut_model, lut_idx);
   end

   logic                   handshake;
   assign handshake = valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         model_q <= 2'd0;
         idx_q   <= 4'd0;
         num_q   <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
         v0_q    <= '0;
         v1_q    <= '0;
         v2_q    <= '0;
         color_q <= '0;
`ifdef SCENE_OBJ_SCALE_EN
         scale_q <= 2'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  state_q <= EMIT;
                  model_q <= model_select;
                  num_q   <= lut_num;
                  idx_q   <= 4'd0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef SCENE_OBJ_SCALE_EN
                  scale_q <= scale_shift;
`endif
                  v0_q    <= vertex(lut_model, lut_tri[20:18], shift_d);
                  v1_q    <= vertex(lut_model, lut_tri[17:15], shift_d);
                  v2_q    <= vertex(lut_model, lut_tri[14:12], shift_d);
                  color_q <= lut_tri[11:0];
                  last_q  <= (lut_idx == lut_num - 4'd1);
               end
            end
            default: begin
               if (handshake) begin
                  if (idx_q == num_q - 4'd1) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= lut_idx;
                     v0_q    <= vertex(lut_model, lut_tri[20:18], shift_d);
                     v1_q    <= vertex(lut_model, lut_tri[17:15], shift_d);
                     v2_q    <= vertex(lut_model, lut_tri[14:12], shift_d);
                     color_q <= lut_tri[11:0];
                     last_q  <= (lut_idx == lut_num - 4'd1);
                  end
               end
            end
         endcase
      end
   end

   assign out_valid     = valid_q;
   assign out_v0        = v0_q;
   assign out_v1        = v1_q;
   assign out_v2        = v2_q;
   assign out_color     = color_q;
   assign out_tri_idx   = idx_q;
   assign out_last      = last_q;
   assign num_triangles = num_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;

endmodule

// File: tb/tb_scene_object_streamer.sv
// Directed bench for scene_object_streamer: reset state, full cube frame,
// stalled tetrahedron frame, ignored mid-frame requests, mid-frame reset,
// back-to-back start on frame_done, and (with SCENE_OBJ_SCALE_EN) scaling.

module tb_scene_object_streamer;

   localparam int CW = 10;
   localparam int VW = 3 * CW;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    model_select;
   logic          frame_start;
   logic          out_ready;
   logic          out_valid;
   logic [VW-1:0] out_v0, out_v1, out_v2;
   logic [11:0]   out_color;
   logic [3:0]    out_tri_idx;
   logic          out_last;
   logic [3:0]    num_triangles;
   logic          busy;
   logic          frame_done;
`ifdef SCENE_OBJ_SCALE_EN
   logic [1:0]    scale_shift;
`endif

   int checks = 0;
   int errors = 0;

   scene_object_streamer #(.COORD_W(CW), .OBJ_SIZE(80)) dut (
      .clk           (clk),
      .rst           (rst),
      .model_select  (model_select),
      .frame_start   (frame_start),
`ifdef SCENE_OBJ_SCALE_EN
      .scale_shift   (scale_shift),
`endif
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_v0        (out_v0),
      .out_v1        (out_v1),
      .out_v2        (out_v2),
      .out_color     (out_color),
      .out_tri_idx   (out_tri_idx),
      .out_last      (out_last),
      .num_triangles (num_triangles),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] vec(input int x, input int y, input int z);
      logic signed [CW-1:0] a, b, c;
      a = CW'(x);
      b = CW'(y);
      c = CW'(z);
      return {a, b, c};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Tetrahedron reference beats
   logic [VW-1:0] tet_v0 [4];
   logic [VW-1:0] tet_v1 [4];
   logic [VW-1:0] tet_v2 [4];
   logic [11:0]   tet_c  [4];

   initial begin
      tet_v0[0] = vec(80, 80, 80);   tet_v1[0] = vec(-80, -80, 80); tet_v2[0] = vec(-80, 80, -80); tet_c[0] = 12'hF00;
      tet_v0[1] = vec(80, 80, 80);   tet_v1[1] = vec(80, -80, -80); tet_v2[1] = vec(-80, -80, 80); tet_c[1] = 12'h0F0;
      tet_v0[2] = vec(80, 80, 80);   tet_v1[2] = vec(-80, 80, -80); tet_v2[2] = vec(80, -80, -80); tet_c[2] = 12'h00F;
      tet_v0[3] = vec(-80, -80, 80); tet_v1[3] = vec(80, -80, -80); tet_v2[3] = vec(-80, 80, -80); tet_c[3] = 12'hFF0;

      rst = 1'b1;
      model_select = 2'd0;
      frame_start = 1'b0;
      out_ready = 1'b0;
`ifdef SCENE_OBJ_SCALE_EN
      scale_shift = 2'd0;
`endif
      step();
      step();

      // Reset state
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_v0", out_v0, 0);
      chk("rst_v2", out_v2, 0);
      chk("rst_color", out_color, 0);
      chk("rst_idx", out_tri_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_num", num_triangles, 0);
      rst = 1'b0;
      step();

      // Cube frame, consumer always ready
      model_select = 2'd0;
      out_ready = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("cube_v0", out_v0, vec(80, 80, 80));
      chk("cube_v1", out_v1, vec(-80, 80, 80));
      chk("cube_v2", out_v2, vec(-80, -80, 80));
      chk("cube_color", out_color, 12'hF00);
      chk("cube_num", num_triangles, 12);
      for (int i = 0; i < 12; i++) begin
         chk("cube_valid", out_valid, 1);
         chk("cube_busy", busy, 1);
         chk("cube_idx", out_tri_idx, i);
         chk("cube_last", out_last, (i == 11));
         chk("cube_done_low", frame_done, 0);
         if (i == 6) begin
            chk("cube6_v2", out_v2, vec(-80, -80, -80));
            chk("cube6_color", out_color, 12'hFF0);
         end
         if (i == 11) begin
            chk("cube11_v0", out_v0, vec(-80, 80, 80));
            chk("cube11_v1", out_v1, vec(-80, -80, -80));
            chk("cube11_v2", out_v2, vec(-80, -80, 80));
            chk("cube11_color", out_color, 12'hF0F);
         end
         step();
      end
      chk("cube_end_valid", out_valid, 0);
      chk("cube_end_busy", busy, 0);
      chk("cube_end_done", frame_done, 1);
      step();
      chk("cube_done_pulse", frame_done, 0);

      // Tetrahedron with ready toggling 1,0,1,0,...
      model_select = 2'd3;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("tet_num", num_triangles, 4);
      for (int c = 0; c < 7; c++) begin
         int b;
         b = (c + 1) / 2;
         out_ready = (c % 2 == 0);
         chk("tet_valid", out_valid, 1);
         chk("tet_idx", out_tri_idx, b);
         chk("tet_v0", out_v0, tet_v0[b]);
         chk("tet_v1", out_v1, tet_v1[b]);
         chk("tet_v2", out_v2, tet_v2[b]);
         chk("tet_color", out_color, tet_c[b]);
         chk("tet_last", out_last, (b == 3));
         step();
      end
      chk("tet_end_valid", out_valid, 0);
      chk("tet_end_done", frame_done, 1);
      out_ready = 1'b1;
      step();

      // Pyramid with model change and extra frame_start mid-frame
      model_select = 2'd1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("pyr_v0", out_v0, vec(0, -80, 0));
      chk("pyr_v1", out_v1, vec(80, 80, 80));
      chk("pyr_v2", out_v2, vec(-80, 80, 80));
      chk("pyr_color", out_color, 12'hF00);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            model_select = 2'd2;
            frame_start = 1'b1;
         end
         if (i == 3) frame_start = 1'b0;
         chk("pyr_valid", out_valid, 1);
         chk("pyr_idx", out_tri_idx, i);
         chk("pyr_num", num_triangles, 6);
         if (i == 5) begin
            chk("pyr5_v1", out_v1, vec(80, 80, -80));
            chk("pyr5_color", out_color, 12'h0FF);
            chk("pyr5_last", out_last, 1);
         end
         step();
      end
      chk("pyr_end_valid", out_valid, 0);
      chk("pyr_end_done", frame_done, 1);
      step();
      chk("pyr_no_restart", out_valid, 0);

      // Octahedron, reset at idx 4
      model_select = 2'd2;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("oct_idx", out_tri_idx, i);
         step();
      end
      chk("oct_idx4", out_tri_idx, 4);
      chk("oct4_color", out_color, 12'h0FF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("oct_rst_valid", out_valid, 0);
      chk("oct_rst_busy", busy, 0);
      chk("oct_rst_done", frame_done, 0);
      chk("oct_rst_idx", out_tri_idx, 0);
      chk("oct_rst_num", num_triangles, 0);
      step();
      chk("oct_rst_no_done", frame_done, 0);

      // Octahedron restart, full frame
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("oct_v0", out_v0, vec(0, 80, 0));
      chk("oct_v1", out_v1, vec(0, 0, 80));
      chk("oct_v2", out_v2, vec(80, 0, 0));
      chk("oct_num", num_triangles, 8);
      for (int i = 0; i < 8; i++) begin
         chk("oct_valid", out_valid, 1);
         chk("oct_run_idx", out_tri_idx, i);
         if (i == 7) begin
            chk("oct7_v0", out_v0, vec(0, -80, 0));
            chk("oct7_v1", out_v1, vec(0, 0, -80));
            chk("oct7_color", out_color, 12'h888);
            chk("oct7_last", out_last, 1);
         end
         step();
      end
      chk("oct_end_done", frame_done, 1);

      // frame_start in the frame_done cycle starts a new cube frame
      model_select = 2'd0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_idx", out_tri_idx, 0);
      chk("b2b_num", num_triangles, 12);
      chk("b2b_done", frame_done, 0);
      out_ready = 1'b0;
      step();
      chk("b2b_stall_idx", out_tri_idx, 0);
      chk("b2b_stall_v0", out_v0, vec(80, 80, 80));
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("b2b_run_idx", out_tri_idx, i);
         step();
      end
      chk("b2b_end_done", frame_done, 1);
      step();

`ifdef SCENE_OBJ_SCALE_EN
      // Scaled cube, scale_shift change mid-frame ignored
      model_select = 2'd0;
      scale_shift = 2'd3;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      scale_shift = 2'd0;
      chk("scl_v0", out_v0, vec(10, 10, 10));
      chk("scl_v2", out_v2, vec(-10, -10, 10));
      step();
      chk("scl1_v1", out_v1, vec(-10, -10, 10));
      chk("scl1_v2", out_v2, vec(10, -10, 10));
      for (int i = 1; i < 12; i++) step();
      chk("scl_end_done", frame_done, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
